ext_pipe: RTL
=============

# ext_pipe

Registered, parametrised immediate-extension stage for the pipelined datapath. It accepts an IMM_W-bit immediate and a 3-bit mode over a valid/ready handshake. It produces a DATA_W-bit sign-, zero- or upper-extended value, a scaled branch offset, or a full branch target. The stage sits between instruction decode and the ID/EX register, so extension and branch-target addition are removed from the decode critical path and back-pressure from EX is absorbed.

## Interface
- IMM_W, 16, immediate width; 2 ≤ IMM_W ≤ DATA_W-2
- DATA_W, 32, result and PC width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  stage accepts a word this cycle
- in_imm  in  IMM_W  raw immediate
- in_mode  in  3  extension mode
- in_pc  in  DATA_W  PC+4 of the instruction; used by mode 100 only
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result this cycle
- out_data  out  DATA_W  extended result
- out_err  out  1  the mode of this result was reserved

## Operation
- Transfer occurs when valid && ready on the same edge; an input is accepted only when in_valid && in_ready.
- Let S = in_imm sign-extended to DATA_W and Z = in_imm zero-extended to DATA_W.
- Modes:
  - 000: S.
  - 001: Z.
  - 010: in_imm placed in bits [DATA_W-1 : DATA_W-IMM_W], low bits 0.
  - 011: S << 2; the top two bits are discarded.
  - 100: in_pc + (S << 2), modulo 2^DATA_W; no carry or overflow output.
  - 101, 110, 111: out_data = 0, out_err = 1.
- out_err = 0 for all defined modes. out_data and out_err travel together with their word.
- The result is computed combinationally from the inputs and captured at acceptance. Nothing downstream of capture depends on live inputs.
- Results are delivered in acceptance order; none is dropped or duplicated.
- While out_valid=1 && out_ready=0, out_data and out_err hold stable.
- reset=1 on an edge:
  - Discards all held words, including a word mid-handshake.
  - Any input on that edge is not accepted.
  - Reset values: out_valid 0, out_data 0, out_err 0.
  - in_ready after reset is given under Configuration.

## Timing
- Latency is 1 cycle: a word accepted at edge N is visible on out_* after edge N, and can transfer at edge N+1 at the earliest.
- Throughput is one word per cycle when out_ready is held at 1.
- Simultaneous accept and drain in the same cycle: the drained word leaves, the new word enters, and occupancy is unchanged.
- out_valid, out_data and out_err are driven directly from registers, with no combinational path from inputs.

## Configuration
- EXT_SKID_EN defined:
  - Two-entry skid buffer with an occupancy counter of 0..2.
  - in_ready is registered and equals (occupancy < 2); there is no combinational path from out_ready to in_ready.
  - The output comes from the head entry.
  - With one entry held, out_ready=0 and in_valid=1, the second entry fills and in_ready drops on the next cycle.
  - in_ready = 1 after reset.
- EXT_SKID_EN undefined:
  - Single output register.
  - in_ready = !out_valid || out_ready, combinationally.
  - in_ready = 1 after reset.
- Behaviour at the output port is identical in both builds for any stimulus that respects the handshake. Only in_ready timing differs.

## Test plan
- Reset with out_ready=1, then stream modes 000/001/010/011 with in_imm=16'h8004 -> out_data = FFFF8004, 00008004, 80040000, FFFE0010 on consecutive cycles; out_err=0 throughout.
- Mode 100, in_pc=32'h00003000, in_imm=16'hFFFF -> out_data = 00002FFC. Wrap case: in_pc=32'hFFFFFFFC, in_imm=16'h0002 -> out_data = 00000004.
- Mode 110 with in_imm=16'h1234 -> out_data=0, out_err=1. The following word, mode 001 with in_imm=16'h0001 -> out_data=00000001, out_err=0.
- Hold out_ready=0 and drive 3 back-to-back words A, B, C. With EXT_SKID_EN: A and B are accepted and in_ready=0 while C waits. Without it: only A is accepted. Release out_ready -> A, B, C emerge in order, each exactly once, with out_data stable during stall cycles.
- Random valid/ready toggling over 1000 words against a scoreboard -> no loss, duplication or reordering. Full rate is sustained when out_ready is held at 1.
- Assert reset for one cycle while two words are held and in_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1. The word presented during reset never appears.

Source files
------------

// File: rtl/ext_pipe.sv
// Registered immediate-extension stage: sign/zero/upper extension, scaled branch offset, branch target.
// Define EXT_SKID_EN for a two-entry skid buffer with registered in_ready; default is a single output register.
module ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam int PAD = DATA_W - IMM_W;

    typedef enum logic [2:0] {
        MODE_SEXT   = 3'b000,
        MODE_ZEXT   = 3'b001,
        MODE_UPPER  = 3'b010,
        MODE_OFFSET = 3'b011,
        MODE_TARGET = 3'b100
    } mode_e;

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic              accept;
    logic              drain;

    always_comb begin
        sext     = {{PAD{in_imm[IMM_W-1]}}, in_imm};
        zext     = {{PAD{1'b0}}, in_imm};
        res_data = '0;
        res_err  = 1'b0;
        case (in_mode)
            MODE_SEXT:   res_data = sext;
            MODE_ZEXT:   res_data = zext;
            MODE_UPPER:  res_data = {in_imm, {PAD{1'b0}}};
            MODE_OFFSET: res_data = sext << 2;
            MODE_TARGET: res_data = in_pc + (sext << 2);
            default:     res_err  = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

`ifdef EXT_SKID_EN
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] tail_data;
    logic              head_err;
    logic              tail_err;
    logic              out_valid_q;
    logic              in_ready_q;

    assign count_next = count + 2'(accept) - 2'(drain);

    // NOTE: in_ready and out_valid are precomputed from the next occupancy so both leave
    // the block straight from flops; out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            head_data   <= '0;
            tail_data   <= '0;
            head_err    <= 1'b0;
            tail_err    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case ({accept, drain})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= res_data;
                        head_err  <= res_err;
                    end else begin
                        tail_data <= res_data;
                        tail_err  <= res_err;
                    end
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_err  <= tail_err;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_data <= res_data;
                        head_err  <= res_err;
                    end else begin
                        head_data <= tail_data;
                        head_err  <= tail_err;
                        tail_data <= res_data;
                        tail_err  <= res_err;
                    end
                end
                default: ;
            endcase
            count       <= count_next;
            out_valid_q <= (count_next != 2'd0);
            in_ready_q  <= (count_next != 2'd2);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_data;
    assign out_err   = head_err;
`else
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              valid_q;

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept) begin
            data_q  <= res_data;
            err_q   <= res_err;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;
`endif

endmodule
